// File: rtl/piccolo_inv_diffusion.sv
// piccolo_inv_diffusion: sequential inverse Piccolo diffusion, Q = circ(E,B,D,9) * A over GF(2^4), one row per cycle.
// Optional PICCOLO_INVDIFF_SELFCHECK_EN adds chk_err, re-applying the forward matrix to each result.
module piccolo_inv_diffusion #(
  parameter logic [3:0] MOD_POLY = 4'h3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
`ifdef PICCOLO_INVDIFF_SELFCHECK_EN
  ,
  output logic        chk_err
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [15:0] INV_ROW = 16'hEBD9;
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'({1'b1, MOD_POLY}) << (i - 4));
    return p[3:0];
  endfunction
  // Row r of a circulant whose first row is c: coefficient for column j is c[(j-r) mod 4].
  function automatic logic [3:0] row_mix(input logic [15:0] c, input logic [15:0] a, input logic [1:0] r);
    logic [3:0] acc;
    logic [1:0] k;
    acc = '0;
    for (int j = 0; j < 4; j++) begin
      k = 2'(j) - r;
      acc = acc ^ gf_mul(c[15-4*k -: 4], a[15-4*j -: 4]);
    end
    return acc;
  endfunction
  state_t      state_q;
  logic [1:0]  row_q;
  logic [15:0] lat_q, out_q, out_d;
  logic        out_valid_q, in_ready_q;
  always_comb begin
    out_d = out_q;
    out_d[15-4*row_q -: 4] = row_mix(INV_ROW, lat_q, row_q);
  end
`ifdef PICCOLO_INVDIFF_SELFCHECK_EN
  localparam logic [15:0] FWD_ROW = 16'h2311;
  logic [15:0] fwd;
  logic        chk_err_q;
  always_comb begin
    fwd = '0;
    for (int r = 0; r < 4; r++) fwd[15-4*r -: 4] = row_mix(FWD_ROW, out_d, 2'(r));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else if (state_q == CALC && row_q == 2'd3) chk_err_q <= fwd != lat_q;
    else if (state_q == DONE && out_ready) chk_err_q <= 1'b0;
  end
  assign chk_err = chk_err_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= 2'd0;
      lat_q       <= 16'h0000;
      out_q       <= 16'h0000;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          lat_q      <= in_data;
          row_q      <= 2'd0;
          in_ready_q <= 1'b0;
          state_q    <= CALC;
        end
        CALC: begin
          out_q <= out_d;
          row_q <= row_q + 2'd1;
          if (row_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
endmodule

// File: tb/tb_piccolo_inv_diffusion.sv
// tb_piccolo_inv_diffusion: vector table, handshake corner cases and random round trips through a
// matrix-level GF(2^4) model of the forward and inverse Piccolo diffusion.
module tb_piccolo_inv_diffusion;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
`ifdef PICCOLO_INVDIFF_SELFCHECK_EN
  logic        chk_err;
`endif
  int checks = 0;
  int errors = 0;
  int inv_m[4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
  int fwd_m[4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};

  piccolo_inv_diffusion #(.MOD_POLY(4'h3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PICCOLO_INVDIFF_SELFCHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  // GF(2^4) multiply by shift-and-add with xtime reduction by x^4 = x + 1.
  function automatic int gmul(int a, int b);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      if ((b >> i) & 1) r ^= a;
      a = (a & 8) ? (((a << 1) & 15) ^ 3) : ((a << 1) & 15);
    end
    return r;
  endfunction

  function automatic logic [15:0] matmul(input bit inv, input logic [15:0] v);
    logic [15:0] q = '0;
    for (int r = 0; r < 4; r++) begin
      int acc = 0;
      for (int j = 0; j < 4; j++) acc ^= gmul(inv ? inv_m[r][j] : fwd_m[r][j], (v >> (12 - 4 * j)) & 15);
      q = q | (16'(acc) << (12 - 4 * r));
    end
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic accept(input logic [15:0] x);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_word(input logic [15:0] x, output logic [15:0] y, output int lat);
    accept(x);
    wait_valid(lat);
    y = out_data;
`ifdef PICCOLO_INVDIFF_SELFCHECK_EN
    chk("chk_err", 32'(chk_err), 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [15:0] y, x, held;
    int          lat;
    vecs[0] = '{16'h1000, 16'hE9DB};
    vecs[1] = '{16'h0001, 16'h9DBE};
    vecs[2] = '{16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'h0000, 16'h0000};
    vecs[4] = '{16'h0100, 16'hBE9D};
    vecs[5] = '{16'h0010, 16'hDBE9};
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'h0);

    for (int i = 0; i < 6; i++) begin
      chk("model_vs_table", 32'(matmul(1'b1, vecs[i].din)), 32'(vecs[i].exp));
      run_word(vecs[i].din, y, lat);
      chk("vec_latency", 32'(lat), 32'd4);
      chk("vec_out_data", 32'(y), 32'(vecs[i].exp));
      chk("vec_released", 32'({out_valid, in_ready}), 32'b01);
    end

    // Back-pressure: result must hold while out_ready stays low.
    accept(16'h1000);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'({out_valid, in_ready, out_data}), {14'd0, 2'b10, 16'hE9DB});
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", 32'({out_valid, in_ready}), 32'b01);

    // New data offered throughout CALC/DONE, and together with out_ready in DONE.
    accept(16'h0001);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    wait_valid(lat);
    chk("busy_out_data", 32'(out_data), 32'h9DBE);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("busy_done_hs", 32'({out_valid, in_ready}), 32'b01);
    tick();
    in_valid = 1'b0;
    chk("busy_second_accepted", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("busy_second_latency", 32'(lat), 32'd4);
    chk("busy_second_data", 32'(out_data), 32'hFFFF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset on the second CALC cycle abandons the word.
    accept(16'h0001);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'({out_valid, out_data}), 32'h0);
    tick();
    chk("midrst_held", 32'({out_valid, in_ready}), 32'b01);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("midrst_no_valid", 32'({out_valid, in_ready}), 32'b01);
    end
    run_word(16'h1000, y, lat);
    chk("midrst_next_lat", 32'(lat), 32'd4);
    chk("midrst_next_data", 32'(y), 32'hE9DB);

    // Random round trips through the forward diffusion.
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      held = matmul(1'b0, x);
      run_word(held, y, lat);
      chk("roundtrip", 32'(y), 32'(x));
      if (i < 20) chk("roundtrip_model", 32'(matmul(1'b1, held)), 32'(x));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
